jtdd2_prog_buf: RTL and testbench

//  Download-path write buffer between the game's ROM loader outputs
//  (prog_addr/prog_data/prog_mask/prog_we) and the SDRAM write port.

---
 rtl/jtdd2_prog_buf.sv | 161 ++++++++++++++++
 tb/tb_jtdd2_prog_buf.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtdd2_prog_buf.sv
// Download write buffer: merges byte writes that hit the same 16-bit word, queues them,
// and hands them to the SDRAM write port with a req/ack handshake.
module jtdd2_prog_buf #(
   parameter int FIFO_AW = 3,
   parameter int MERGE   = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               downloading,
   input  logic [21:0]        prog_addr,
   input  logic [7:0]         prog_data,
   input  logic [1:0]         prog_mask,
   input  logic               prog_we,
   output logic               sdram_req,
   output logic [21:0]        sdram_addr,
   output logic [15:0]        sdram_din,
   output logic [1:0]         sdram_mask,
   input  logic               sdram_ack,
   output logic               dwnld_busy,
   output logic               ovf,
   output logic [FIFO_AW:0]   level,
   output logic [1:0]         dbg_state
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, GAP = 2'd2} state_t;
   typedef struct packed {
      logic [21:0] addr;
      logic [15:0] data;
      logic [1:0]  mask;
   } entry_t;

   state_t             state_q;
   entry_t             mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   level_q;
   logic               ovf_q, dl_q, req_q;
   entry_t             out_q;

   logic   acc, push, pop, push_ok, fifo_empty, fifo_full, h_busy;
   entry_t strobe_e, push_e;

   // Valid/ready: a write is transferred on the clock edge where sdram_req and sdram_ack are both high;
   // sdram_req and the sdram_* payload stay stable from assertion until that edge.
   assign acc      = prog_we & downloading & (prog_mask != 2'b11);
   assign strobe_e = {prog_addr, prog_data, prog_data, prog_mask};

   generate
      if (MERGE != 0) begin : g_merge
         logic   h_valid_q, h_valid_d, flush, mergeable;
         entry_t h_q, h_d;

         // A complete word or the end of the download empties the hold register ahead of any new load.
         assign flush     = h_valid_q & ((h_q.mask == 2'b00) | ~downloading);
         assign mergeable = h_valid_q & ~flush & (prog_addr == h_q.addr) &
                            ((prog_mask | h_q.mask) == 2'b11);
         assign h_busy    = h_valid_q;

         always_comb begin
            push      = 1'b0;
            push_e    = h_q;
            h_valid_d = h_valid_q;
            h_d       = h_q;
            if (flush) begin
               push      = 1'b1;
               h_valid_d = 1'b0;
            end
            if (acc) begin
               if (mergeable) begin
                  h_d.mask = prog_mask & h_q.mask;
                  if (!prog_mask[0]) h_d.data[7:0]  = prog_data;
                  if (!prog_mask[1]) h_d.data[15:8] = prog_data;
               end else begin
                  if (h_valid_q) push = 1'b1;
                  h_valid_d = 1'b1;
                  h_d       = strobe_e;
               end
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               h_valid_q <= 1'b0;
               h_q       <= '0;
            end else begin
               h_valid_q <= h_valid_d;
               h_q       <= h_d;
            end
         end
      end else begin : g_direct
         assign push   = acc;
         assign push_e = strobe_e;
         assign h_busy = 1'b0;
      end
   endgenerate

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == FULL_LVL);
   // GAP also pops, so back-to-back writes see sdram_req low for a single cycle.
   assign pop        = ~fifo_empty & ((state_q == IDLE) | (state_q == GAP));
   assign push_ok    = push & (~fifo_full | pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_e;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         dl_q     <= 1'b0;
      end else begin
         dl_q <= downloading;
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_q + {{FIFO_AW{1'b0}}, push_ok} - {{FIFO_AW{1'b0}}, pop};
         if (downloading & ~dl_q)  ovf_q <= 1'b0;
         else if (push & ~push_ok) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         out_q   <= {22'd0, 16'd0, 2'b11};
      end else begin
         case (state_q)
            IDLE, GAP: begin
               if (pop) begin
                  out_q   <= mem_q[rd_ptr_q];
                  req_q   <= 1'b1;
                  state_q <= WAIT;
               end else begin
                  state_q <= IDLE;
               end
            end
            WAIT: begin
               if (sdram_ack) begin
                  req_q   <= 1'b0;
                  state_q <= GAP;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sdram_req  = req_q;
   assign sdram_addr = out_q.addr;
   assign sdram_din  = out_q.data;
   assign sdram_mask = out_q.mask;
   assign ovf        = ovf_q;
   assign level      = level_q;
   assign dwnld_busy = downloading | h_busy | ~fifo_empty | req_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_jtdd2_prog_buf.sv
// Bench for jtdd2_prog_buf: a MERGE=0 and a MERGE=1 instance share the loader inputs and are
// scored against a word-level model of the expected SDRAM write stream.
module tb_jtdd2_prog_buf;
   logic        clk = 1'b0;
   logic        rst;
   logic        downloading, prog_we;
   logic [21:0] prog_addr;
   logic [7:0]  prog_data;
   logic [1:0]  prog_mask;

   logic        req0, req1, ack0, ack1, busy0, busy1, ovf0, ovf1;
   logic [21:0] addr0, addr1;
   logic [15:0] din0, din1;
   logic [1:0]  mask0, mask1, st0, st1;
   logic [3:0]  level0, level1;

   int n_checks = 0;
   int n_errors = 0;

   logic [39:0] exp0_q[$];
   logic [39:0] exp1_q[$];
   logic [39:0] last1;
   int          wr_cnt0 = 0;

   // word-level model of the merging hold register
   logic        h_v;
   logic [21:0] h_a;
   logic [15:0] h_d;
   logic [1:0]  h_m;

   logic ack_en0, ack_en1, gap_en;
   int   dly_lo, dly_hi;

   always #5 clk = ~clk;

   jtdd2_prog_buf #(.FIFO_AW(3), .MERGE(0)) u_m0 (
      .clk(clk), .rst(rst), .downloading(downloading), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_mask(prog_mask), .prog_we(prog_we),
      .sdram_req(req0), .sdram_addr(addr0), .sdram_din(din0), .sdram_mask(mask0),
      .sdram_ack(ack0), .dwnld_busy(busy0), .ovf(ovf0), .level(level0), .dbg_state(st0)
   );

   jtdd2_prog_buf #(.FIFO_AW(3), .MERGE(1)) u_m1 (
      .clk(clk), .rst(rst), .downloading(downloading), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_mask(prog_mask), .prog_we(prog_we),
      .sdram_req(req1), .sdram_addr(addr1), .sdram_din(din1), .sdram_mask(mask1),
      .sdram_ack(ack1), .dwnld_busy(busy1), .ovf(ovf1), .level(level1), .dbg_state(st1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_strobe(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
      exp0_q.push_back({a, d, d, m});
      if (h_v && h_a == a && (m | h_m) == 2'b11) begin
         if (!m[0]) h_d[7:0]  = d;
         if (!m[1]) h_d[15:8] = d;
         h_m = m & h_m;
      end else begin
         if (h_v) exp1_q.push_back({h_a, h_d, h_m});
         h_v = 1'b1; h_a = a; h_d = {d, d}; h_m = m;
      end
      if (h_m == 2'b00) begin
         exp1_q.push_back({h_a, h_d, h_m});
         h_v = 1'b0;
      end
   endtask

   task automatic model_flush();
      if (h_v) exp1_q.push_back({h_a, h_d, h_m});
      h_v = 1'b0;
   endtask

   task automatic drive(input logic we, input logic dl, input logic [21:0] a,
                        input logic [7:0] d, input logic [1:0] m);
      prog_we = we; downloading = dl; prog_addr = a; prog_data = d; prog_mask = m;
      if (we && dl && m != 2'b11) model_strobe(a, d, m);
      if (!dl) model_flush();
      @(posedge clk); #1;
   endtask

   task automatic log_write(input int k, input logic [39:0] got);
      logic [39:0] e;
      if (k == 0) begin
         if (exp0_q.size() == 0) begin check("m0_extra_write", 1, 0); return; end
         e = exp0_q.pop_front();
         wr_cnt0++;
         check("m0_write", got, e);
      end else begin
         last1 = got;
         if (exp1_q.size() == 0) begin check("m1_extra_write", 1, 0); return; end
         e = exp1_q.pop_front();
         check("m1_write", got, e);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy0 || busy1) && n < 3000) begin @(posedge clk); #1; n++; end
      check(tag, {busy0, busy1}, 2'b00);
   endtask

   // ack responders; a write is logged at the negedge where ack is raised under a held req
   initial begin : resp0
      int dly = 0;
      int low_run = 0;
      logic prev = 1'b0;
      logic seen = 1'b0;
      ack0 = 1'b0;
      forever begin
         @(negedge clk);
         if (gap_en) begin
            if (req0 && !prev && seen) check("m0_req_gap", low_run, 1);
            if (req0 && !prev) seen = 1'b1;
            low_run = req0 ? 0 : low_run + 1;
         end else begin
            seen = 1'b0;
            low_run = 0;
         end
         prev = req0;
         if (rst) ack0 = 1'b0;
         else if (ack_en0 && req0 && !ack0) begin
            if (dly == 0) begin ack0 = 1'b1; log_write(0, {addr0, din0, mask0}); end
            else dly--;
         end else begin
            ack0 = 1'b0;
            dly = $urandom_range(dly_hi, dly_lo);
         end
      end
   end

   initial begin : resp1
      int dly = 0;
      ack1 = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) ack1 = 1'b0;
         else if (ack_en1 && req1 && !ack1) begin
            if (dly == 0) begin ack1 = 1'b1; log_write(1, {addr1, din1, mask1}); end
            else dly--;
         end else begin
            ack1 = 1'b0;
            dly = $urandom_range(dly_hi, dly_lo);
         end
      end
   end

   initial begin : main
      int base;
      rst = 1'b1; downloading = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      prog_mask = 2'b11; ack_en0 = 1'b1; ack_en1 = 1'b1; gap_en = 1'b0;
      dly_lo = 0; dly_hi = 2; h_v = 1'b0; h_a = '0; h_d = '0; h_m = 2'b11; last1 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req",   {req0, req1}, 2'b00);
      check("rst_addr0", addr0, 22'd0);
      check("rst_din0",  din0, 16'd0);
      check("rst_mask",  {mask0, mask1}, 4'b1111);
      check("rst_ovf",   {ovf0, ovf1}, 2'b00);
      check("rst_level", {level0, level1}, 8'd0);
      check("rst_busy",  {busy0, busy1}, 2'b00);
      rst = 1'b0;

      // ignored strobes: lane mask 11, or not downloading
      drive(1, 1, 22'h10, 8'hAA, 2'b11);
      check("ign_mask_level", {level0, level1}, 8'd0);
      check("ign_mask_busy", {busy0, busy1}, 2'b11);
      drive(1, 0, 22'h11, 8'hBB, 2'b10);
      drive(0, 0, 22'h0, 8'h0, 2'b11);
      check("ign_dl_level", {level0, level1}, 8'd0);
      check("ign_dl_busy", {busy0, busy1}, 2'b00);

      // MERGE=0 latency from idle
      drive(1, 1, 22'h200, 8'h5A, 2'b10);
      check("lat_level_n1", level0, 4'd1);
      check("lat_req_n1", req0, 1'b0);
      drive(0, 1, 22'h0, 8'h0, 2'b11);
      check("lat_req_n2", req0, 1'b1);
      check("lat_out_n2", {addr0, din0, mask0}, {22'h200, 16'h5A5A, 2'b10});
      check("lat_m1_held", {level1, req1, busy1}, 6'b0000_0_1);

      // complementary lanes of one word merge into a single write
      drive(1, 1, 22'h100, 8'h12, 2'b10);
      drive(1, 1, 22'h100, 8'h34, 2'b01);
      repeat (20) drive(0, 1, 22'h0, 8'h0, 2'b11);
      check("merge_word", last1, {22'h100, 16'h3412, 2'b00});

      // different address: first byte written alone, second flushed when downloading falls
      drive(1, 1, 22'h100, 8'h56, 2'b10);
      drive(1, 1, 22'h101, 8'h78, 2'b10);
      repeat (10) drive(0, 1, 22'h0, 8'h0, 2'b11);
      check("nomerge_first", last1, {22'h100, 16'h5656, 2'b10});
      drive(0, 0, 22'h0, 8'h0, 2'b11);
      check("flush_busy", busy1, 1'b1);
      wait_idle("flush_idle");
      check("flush_last", last1, {22'h101, 16'h7878, 2'b10});
      check("flush_m1_empty", exp1_q.size(), 0);

      // overflow: acks held, 10 strobes into 1 in flight + 8 queued
      ack_en0 = 1'b0;
      base = wr_cnt0;
      for (int i = 0; i < 10; i++) drive(1, 1, 22'h300 + 22'(i), 8'(i), 2'b01);
      void'(exp0_q.pop_back());
      drive(0, 1, 22'h0, 8'h0, 2'b11);
      check("ovf_flag", {ovf0, ovf1}, 2'b10);
      check("ovf_level", level0, 4'd8);
      check("ovf_req", req0, 1'b1);
      ack_en0 = 1'b1;
      drive(0, 0, 22'h0, 8'h0, 2'b11);
      wait_idle("ovf_idle");
      check("ovf_writes", wr_cnt0 - base, 9);
      check("ovf_sticky", ovf0, 1'b1);
      drive(0, 1, 22'h0, 8'h0, 2'b11);
      check("ovf_clear", ovf0, 1'b0);

      // back-to-back with ack one cycle after req
      dly_lo = 1; dly_hi = 1; gap_en = 1'b1;
      for (int i = 0; i < 8; i++) drive(1, 1, 22'h400 + 22'(2 * i), 8'($urandom), 2'($urandom_range(0, 2)));
      repeat (40) drive(0, 1, 22'h0, 8'h0, 2'b11);
      gap_en = 1'b0; dly_lo = 0; dly_hi = 2;
      drive(0, 0, 22'h0, 8'h0, 2'b11);
      wait_idle("b2b_idle");

      // asynchronous reset while waiting for ack
      ack_en0 = 1'b0; ack_en1 = 1'b0;
      drive(1, 1, 22'h500, 8'hC3, 2'b00);
      drive(0, 1, 22'h0, 8'h0, 2'b11);
      drive(0, 1, 22'h0, 8'h0, 2'b11);
      check("rstw_pre", {req0, req1, st0}, 4'b11_01);
      #2 rst = 1'b1;
      #1;
      check("rstw_req", {req0, req1}, 2'b00);
      check("rstw_level", {level0, level1}, 8'd0);
      check("rstw_busy_dl1", {busy0, busy1}, 2'b11);
      check("rstw_state", st0, 2'd0);
      downloading = 1'b0;
      #1;
      check("rstw_busy_dl0", {busy0, busy1}, 2'b00);
      exp0_q.delete(); exp1_q.delete(); h_v = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; ack_en0 = 1'b1; ack_en1 = 1'b1;

      // randomized traffic on a few addresses so lanes merge and collide
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 7) == 0, $urandom_range(0, 99) >= 3,
               22'h600 + 22'($urandom_range(0, 3)), 8'($urandom), 2'($urandom_range(0, 3)));
      end
      drive(0, 0, 22'h0, 8'h0, 2'b11);
      wait_idle("rand_idle");
      check("rand_ovf", {ovf0, ovf1}, 2'b00);
      check("left_m0", exp0_q.size(), 0);
      check("left_m1", exp1_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
